demux_1_to_4_buf: RTL and testbench

Buffered 1-to-4 demultiplexer: takes one 16-bit data stream with a 2-bit destination select and delivers each word to one of four output channels, each with its own small FIFO and valid/ready handshake. It is the distribution counterpart of the 4-to-1 datapath selectors. It sits between a single producer (e.g. write-back/result bus) and four independent consumers that may stall separately. Per-channel word order is preserved; no ordering is guaranteed across channels.

---
 rtl/demux_1_to_4_buf.sv | 53 +++++
 tb/tb_demux_1_to_4_buf.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/demux_1_to_4_buf.sv
// demux_1_to_4_buf: routes one valid/ready word stream into four independently drained FIFO channels
module demux_1_to_4_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [WIDTH-1:0] out_data4,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [3:0]       full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] head [4];
  assign in_ready  = rst_n && !full[in_select];
  assign out_data1 = head[0];
  assign out_data2 = head[1];
  assign out_data3 = head[2];
  assign out_data4 = head[3];
  for (genvar g = 0; g < 4; g++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count;
    logic             push, pop;
    assign out_valid[g] = count != '0;
    assign full[g]      = count == (AW+1)'(DEPTH);
    assign push         = in_valid && in_ready && in_select == 2'(g);
    assign pop          = out_valid[g] && out_ready[g];
    assign head[g]      = mem[rd_ptr];
    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
  end
endmodule

// File: tb/tb_demux_1_to_4_buf.sv
// tb_demux_1_to_4_buf: randomized and directed checks against per-channel queue model
module tb_demux_1_to_4_buf;
  localparam int DEPTH = 2;
  logic        clk = 0, rst_n = 0, in_valid = 0, in_ready;
  logic [15:0] in_data = 0, out_data1, out_data2, out_data3, out_data4;
  logic [1:0]  in_select = 0;
  logic [3:0]  out_valid, out_ready = 0, full;
  logic [15:0] q  [4][$];
  logic [15:0] rx [4][$];
  logic [15:0] ex [4][$];
  int pass_cnt = 0, total = 0;

  demux_1_to_4_buf #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_select(in_select),
    .in_valid(in_valid), .in_ready(in_ready), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3), .out_data4(out_data4),
    .out_valid(out_valid), .out_ready(out_ready), .full(full)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dout(input int ch);
    return ch == 0 ? out_data1 : ch == 1 ? out_data2 : ch == 2 ? out_data3 : out_data4;
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = q[i].size() != 0;
    return v;
  endfunction

  function automatic logic [3:0] exp_full();
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = q[i].size() == DEPTH;
    return f;
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      rx[i].delete();
      ex[i].delete();
    end
  endfunction

  // Drives one cycle from a negedge to the next negedge and advances the model.
  task automatic tick(input logic v, input logic [1:0] s, input logic [15:0] d, input logic [3:0] r);
    logic       do_push;
    logic [3:0] do_pop;
    in_valid = v; in_select = s; in_data = d; out_ready = r;
    #1;
    do_push = v && rst_n && q[s].size() < DEPTH;
    for (int i = 0; i < 4; i++) begin
      do_pop[i] = r[i] && q[i].size() != 0;
      if (do_pop[i]) begin
        rx[i].push_back(dout(i));
        ex[i].push_back(q[i][0]);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) if (do_pop[i]) void'(q[i].pop_front());
    if (do_push) q[s].push_back(d);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 4'hf);
    clear_model();
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; in_select = 2'b10; in_data = 16'hffff;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else pass_cnt++;
    total++; if (out_valid !== 4'b0) $display("FAIL reset_out_valid got %b exp 0000", out_valid); else pass_cnt++;
    total++; if (full !== 4'b0) $display("FAIL reset_full got %b exp 0000", full); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++; if (dout(i) !== 16'h0) $display("FAIL reset_out_data%0d got %h exp 0000", i+1, dout(i)); else pass_cnt++;
    end
    in_valid = 0;
    rst_n = 1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b exp 1", in_ready); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_single();
    tick(1, 2'b10, 16'ha5a5, 0);
    total++; if (out_valid !== 4'b0100) $display("FAIL single_valid got %b exp 0100", out_valid); else pass_cnt++;
    total++; if (out_data3 !== 16'ha5a5) $display("FAIL single_data got %h exp a5a5", out_data3); else pass_cnt++;
    tick(0, 0, 0, 4'b0100);
    total++; if (out_valid !== 4'b0000) $display("FAIL single_pop got %b exp 0000", out_valid); else pass_cnt++;
    total++; if (rx[2].size() != 1 || rx[2][0] !== 16'ha5a5) $display("FAIL single_rx got %0d words exp 1 of a5a5", rx[2].size()); else pass_cnt++;
    clear_model();
  endtask

  task automatic test_full();
    tick(1, 2'b01, 16'h0001, 0);
    tick(1, 2'b01, 16'h0002, 0);
    total++; if (full !== 4'b0010) $display("FAIL full_flag got %b exp 0010", full); else pass_cnt++;
    in_valid = 1; in_select = 2'b01; out_ready = 4'b0010; #1;
    total++; if (in_ready !== 1'b0) $display("FAIL full_no_passthru got %b exp 0", in_ready); else pass_cnt++;
    in_select = 2'b00; #1;
    total++; if (in_ready !== 1'b1) $display("FAIL other_ready got %b exp 1", in_ready); else pass_cnt++;
    tick(1, 2'b00, 16'h0bad, 0);
    total++; if (out_valid !== 4'b0011) $display("FAIL full_push_other got %b exp 0011", out_valid); else pass_cnt++;
    total++; if (out_data1 !== 16'h0bad) $display("FAIL full_other_data got %h exp 0bad", out_data1); else pass_cnt++;
    tick(1, 2'b01, 16'h0003, 4'b0010);
    total++; if (out_data2 !== 16'h0002 || full !== 4'b0000) $display("FAIL full_pop_no_push data %h full %b exp 0002 0000", out_data2, full); else pass_cnt++;
    drain();
  endtask

  task automatic test_push_pop();
    tick(1, 2'b11, 16'h1111, 0);
    tick(1, 2'b11, 16'h2222, 4'b1000);
    total++; if (out_valid !== 4'b1000 || full !== 4'b0000) $display("FAIL pushpop_count valid %b full %b exp 1000 0000", out_valid, full); else pass_cnt++;
    total++; if (out_data4 !== 16'h2222) $display("FAIL pushpop_data got %h exp 2222", out_data4); else pass_cnt++;
    drain();
  endtask

  task automatic test_wrap();
    logic saw_full = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1, 2'b00, 16'h0010 + 16'(k), 4'b0001);
      if (full[0]) saw_full = 1;
    end
    tick(0, 0, 0, 4'b0001);
    total++; if (saw_full !== 1'b0) $display("FAIL wrap_full got 1 exp 0"); else pass_cnt++;
    total++; if (rx[0].size() != 6) $display("FAIL wrap_count got %0d exp 6", rx[0].size()); else pass_cnt++;
    for (int k = 0; k < rx[0].size() && k < 6; k++) begin
      total++; if (rx[0][k] !== 16'h0010 + 16'(k)) $display("FAIL wrap_word%0d got %h exp %h", k, rx[0][k], 16'h0010 + 16'(k)); else pass_cnt++;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    tick(1, 2'b00, 16'hc001, 0);
    tick(1, 2'b00, 16'hc002, 0);
    tick(1, 2'b10, 16'hc003, 0);
    tick(1, 2'b10, 16'hc004, 0);
    total++; if (full !== 4'b0101) $display("FAIL mid_prefill got %b exp 0101", full); else pass_cnt++;
    in_valid = 0; out_ready = 4'hf;
    rst_n = 0; #1;
    total++; if (out_valid !== 4'b0 || full !== 4'b0) $display("FAIL mid_reset valid %b full %b exp 0000 0000", out_valid, full); else pass_cnt++;
    total++; if (in_ready !== 1'b0) $display("FAIL mid_reset_ready got %b exp 0", in_ready); else pass_cnt++;
    #1 rst_n = 1;
    clear_model();
    tick(1, 2'b00, 16'h5a5a, 0);
    total++; if (out_valid !== 4'b0001 || out_data1 !== 16'h5a5a) $display("FAIL mid_after valid %b data %h exp 0001 5a5a", out_valid, out_data1); else pass_cnt++;
    tick(0, 0, 0, 4'b0001);
    total++; if (out_valid !== 4'b0000) $display("FAIL mid_sole got %b exp 0000", out_valid); else pass_cnt++;
    drain();
  endtask

  task automatic test_random();
    logic       v;
    logic [1:0] s;
    logic [3:0] r;
    int         bad = 0;
    for (int k = 0; k < 400; k++) begin
      v = 1'($urandom_range(0, 3) != 0);
      s = 2'($urandom);
      r = 4'($urandom);
      in_valid = v; in_select = s; out_ready = r; #1;
      total++; if (in_ready !== (q[s].size() < DEPTH)) begin bad++; $display("FAIL rand_ready cyc %0d got %b", k, in_ready); end else pass_cnt++;
      tick(v, s, 16'($urandom), r);
      total++; if (out_valid !== exp_valid() || full !== exp_full()) begin
        bad++; $display("FAIL rand_flags cyc %0d valid %b full %b exp %b %b", k, out_valid, full, exp_valid(), exp_full());
      end else pass_cnt++;
      for (int i = 0; i < 4; i++) if (q[i].size() != 0) begin
        total++; if (dout(i) !== q[i][0]) begin bad++; $display("FAIL rand_head%0d cyc %0d got %h exp %h", i+1, k, dout(i), q[i][0]); end else pass_cnt++;
      end
      if (bad > 10) break;
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (rx[i] != ex[i]) $display("FAIL rand_stream%0d got %0d words exp %0d", i+1, rx[i].size(), ex[i].size()); else pass_cnt++;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_push_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
